fp_wb_scheduler: RTL

Write-port scheduler and pending-write scoreboard for the 32x32 FP register file. Three writeback sources share the file's single write port: FPU result, FLW load data, and integer-to-FP moves/converts. The block arbitrates them round-robin and drives the registered write port. It also tracks outstanding FP destinations so that issue stalls on RAW/WAW hazards. It sits between the FP execute/memory stages and the FP register file write inputs.

---
 rtl/fp_wb_scheduler.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fp_wb_scheduler.sv
// Round-robin write-port scheduler for the FP regfile plus a pending-destination scoreboard.
// Write port is registered one cycle after the transfer; losing sources are held off by a zero req_ready_o.
module fp_wb_scheduler #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEBUG  = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [2:0]                req_valid_i,
    input  logic [3*REG_AW-1:0]       req_rd_i,
    input  logic [3*DATA_W-1:0]       req_data_i,
    output logic [2:0]                req_ready_o,
    output logic                      wr_en_o,
    output logic [REG_AW-1:0]         wr_rd_o,
    output logic [DATA_W-1:0]         wr_data_o,
    input  logic                      alloc_valid_i,
    input  logic [REG_AW-1:0]         alloc_rd_i,
    input  logic [REG_AW-1:0]         chk_rs1_i,
    input  logic [REG_AW-1:0]         chk_rs2_i,
    input  logic [REG_AW-1:0]         chk_rd_i,
    output logic                      stall_o,
    output logic [(1<<REG_AW)-1:0]    pending_o,
    output logic                      err_o
);

    localparam int NREG = 1 << REG_AW;

    if (DEBUG != 0 && DEBUG != 1) begin : g_debug_chk
        $error("fp_wb_scheduler: DEBUG must be 0 or 1");
    end

    logic [1:0]          ptr_q, ptr_d;
    logic                wr_en_q, wr_en_d;
    logic [REG_AW-1:0]   wr_rd_q, wr_rd_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [NREG-1:0]     pend_q, pend_d;
    logic                err_q, err_d;

    logic [REG_AW-1:0]   src_rd   [3];
    logic [DATA_W-1:0]   src_data [3];
    logic [1:0]          cand     [3];
    logic [1:0]          gnt_idx;
    logic                gnt_any;
    logic                xfer;
    logic [REG_AW-1:0]   sel_rd;
    logic [DATA_W-1:0]   sel_data;
    logic [NREG-1:0]     clr_vec;
    logic [NREG-1:0]     busy_vec;
    logic                alloc_clr_hit;

    for (genvar k = 0; k < 3; k++) begin : g_unpack
        assign src_rd[k]   = req_rd_i[k*REG_AW +: REG_AW];
        assign src_data[k] = req_data_i[k*DATA_W +: DATA_W];
    end

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Candidates in priority order starting at the pointer; scanning from the
    // back lets the closest asserted source overwrite the farther ones.
    always_comb begin
        cand[0] = ptr_q;
        cand[1] = inc3(ptr_q);
        cand[2] = inc3(inc3(ptr_q));
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        for (int i = 2; i >= 0; i--) begin
            if (req_valid_i[cand[i]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[i];
            end
        end
    end

    assign xfer        = gnt_any && !reset;
    assign req_ready_o = xfer ? (3'b001 << gnt_idx) : 3'b000;
    assign sel_rd      = src_rd[gnt_idx];
    assign sel_data    = src_data[gnt_idx];

    assign clr_vec       = wr_en_q ? ({{(NREG-1){1'b0}}, 1'b1} << wr_rd_q) : '0;
    assign alloc_clr_hit = wr_en_q && (wr_rd_q == alloc_rd_i);

    always_comb begin
        ptr_d     = ptr_q;
        wr_en_d   = xfer;
        wr_rd_d   = wr_rd_q;
        wr_data_d = wr_data_q;
        if (xfer) begin
            ptr_d     = inc3(gnt_idx);
            wr_rd_d   = sel_rd;
            wr_data_d = sel_data;
        end
    end

    // Set is applied after clear so a same-cycle alloc keeps the bit.
    always_comb begin
        pend_d = pend_q & ~clr_vec;
        if (alloc_valid_i) begin
            pend_d[alloc_rd_i] = 1'b1;
        end
        err_d = err_q;
        if (alloc_valid_i && pend_q[alloc_rd_i] && !alloc_clr_hit) begin
            err_d = 1'b1;
        end
        if (xfer && !pend_q[sel_rd]) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q     <= 2'd0;
            wr_en_q   <= 1'b0;
            wr_rd_q   <= '0;
            wr_data_q <= '0;
            pend_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_rd_q   <= wr_rd_d;
            wr_data_q <= wr_data_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
        end
    end

    // The regfile bypasses the write in flight, so that register is not a hazard.
    assign busy_vec = pend_q & ~clr_vec;
    assign stall_o  = busy_vec[chk_rs1_i] | busy_vec[chk_rs2_i] | busy_vec[chk_rd_i];

    assign wr_en_o   = wr_en_q;
    assign wr_rd_o   = wr_rd_q;
    assign wr_data_o = wr_data_q;
    assign pending_o = pend_q;
    assign err_o     = err_q;

endmodule
